// File: rtl/div_if.sv
// Divide-unit request/response bundle between execute stage and sequencer.
// The requester drives operands and control; the sequencer returns status and result.
interface div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i,
    output op_i,
    output dividend_i,
    output divisor_i,
    output flush_i,
    input  ready_o,
    input  busy_o,
    input  valid_o,
    input  result_o
  );

  modport slave (
    input  start_i,
    input  op_i,
    input  dividend_i,
    input  divisor_i,
    input  flush_i,
    output ready_o,
    output busy_o,
    output valid_o,
    output result_o
  );
endinterface

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring division, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish on the accept edge.
module div_sequencer #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input logic clk_i,
  input logic rst_i,
  div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    BUSY,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t state;
  state_t state_n;

  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] res_q;
  logic [CNT_W-1:0] cnt;
  logic            neg_q;
  logic            neg_r;

  // Accept-edge classification of the incoming request
  logic            sgn_in;
  logic            div0;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_quo;
  logic [XLEN-1:0] spec_rem;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    sgn_in   = ~bus.op_i[0];
    div0     = (bus.divisor_i == '0);
    ovf      = sgn_in
             & (bus.dividend_i == MIN)
             & (bus.divisor_i == ONES);
    special  = div0 | ovf;
    spec_quo = div0 ? ONES : MIN;
    spec_rem = div0 ? bus.dividend_i : '0;
    spec_res = bus.op_i[1] ? spec_rem : spec_quo;
  end

  // Magnitudes and result signs for the latched operands
  logic            sgn_q;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;

  always_comb begin
    sgn_q = ~op_q[0];
    a_neg = sgn_q & a_q[XLEN-1];
    b_neg = sgn_q & b_q[XLEN-1];
    a_abs = a_neg ? (~a_q + 1'b1) : a_q;
    b_abs = b_neg ? (~b_q + 1'b1) : b_q;
  end

  // One restoring step; the remainder is kept below the divisor so it fits XLEN bits
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;
  logic            last;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;
  logic [XLEN-1:0] fin_res;

  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    trial   = rem_sh - {1'b0, b_q};
    q_bit   = ~trial[XLEN];
    rem_n   = q_bit ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_n   = {quo[XLEN-2:0], q_bit};
    last    = (cnt == '0);
    fin_quo = neg_q ? (~quo_n + 1'b1) : quo_n;
    fin_rem = neg_r ? (~rem_n + 1'b1) : rem_n;
    fin_res = op_q[1] ? fin_rem : fin_quo;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (bus.flush_i) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            state_n = special ? DONE : PREP;
          end
        end
        PREP: state_n = BUSY;
        BUSY: begin
          if (last) begin
            state_n = DONE;
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      quo   <= '0;
      rem   <= '0;
      res_q <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (!bus.flush_i) begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            op_q <= bus.op_i;
            a_q  <= bus.dividend_i;
            b_q  <= bus.divisor_i;
            if (special) begin
              res_q <= spec_res;
            end
          end
        end
        PREP: begin
          quo   <= a_abs;
          b_q   <= b_abs;
          rem   <= '0;
          cnt   <= CNT_W'(XLEN - 1);
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
        BUSY: begin
          rem <= rem_n;
          quo <= quo_n;
          if (last) begin
            res_q <= fin_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o  = (state == IDLE);
  assign bus.busy_o   = (state != IDLE);
  assign bus.valid_o  = (state == DONE);
  assign bus.result_o = res_q;

endmodule
